// File: rtl/riscv_lsu_rmw.sv
// riscv_lsu_rmw: byte/half/word load-store unit with read-modify-write sub-word stores onto a word-only sync RAM; optional LSU_PERF_CNT_EN adds saturating perf counters
module riscv_lsu_rmw #(
   parameter int AW = 7
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic          resp_valid,
   output logic [31:0]   resp_rdata,
   output logic          resp_err,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
`ifdef LSU_PERF_CNT_EN
   ,
   output logic [15:0]   perf_loads,
   output logic [15:0]   perf_stores,
   output logic [15:0]   perf_errs
`endif
);
   typedef enum logic [2:0] {IDLE, ACCESS, RDATA, MERGE, WRITE, RESP, ERR} state_t;
   state_t        r_state, w_next;
   logic [AW+1:0] r_addr;
   logic [1:0]    r_size;
   logic          r_we, r_uns;
   logic [31:0]   r_wdata, r_merge;
   logic          r_resp_valid, r_resp_err;
   logic [31:0]   r_resp_rdata;
   logic          w_accept, w_err, w_word_st;
   logic [31:0]   w_rsh, w_load, w_mask, w_ins, w_merged;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;

   assign w_accept  = req_valid && req_ready;
   assign w_err     = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
   assign w_word_st = r_we && r_size == 2'b10;
   assign w_rsh     = mem_rdata >> {r_addr[1:0], 3'b000};
   assign w_byte    = w_rsh[7:0];
   assign w_half    = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   assign w_load    = r_size == 2'b10 ? mem_rdata :
                      r_size[0] ? {{16{~r_uns & w_half[15]}}, w_half} : {{24{~r_uns & w_byte[7]}}, w_byte};
   assign w_mask    = r_size[0] ? 32'h0000_FFFF << {r_addr[1], 4'b0000} : 32'h0000_00FF << {r_addr[1:0], 3'b000};
   assign w_ins     = r_size[0] ? {2{r_wdata[15:0]}} : {4{r_wdata[7:0]}};
   assign w_merged  = (mem_rdata & ~w_mask) | (w_ins & w_mask);

   // state register; async reset returns to IDLE and drops mem_en immediately
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;

   // next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = w_err ? ERR : ACCESS;
         ACCESS:  w_next = w_word_st ? RESP : (r_we ? MERGE : RDATA);
         RDATA:   w_next = RESP;
         MERGE:   w_next = WRITE;
         WRITE:   w_next = RESP;
         default: w_next = IDLE;
      endcase
   end

   // RAM port and handshake decoded from state and captured request only
   always_comb begin
      req_ready = rst_n && r_state == IDLE;
      mem_en    = r_state == ACCESS || r_state == WRITE;
      mem_we    = r_state == WRITE || (r_state == ACCESS && w_word_st);
      mem_addr  = r_addr[AW+1:2];
      mem_wdata = r_state == WRITE ? r_merge : (r_state == ACCESS && w_word_st) ? r_wdata : '0;
   end

   // request capture, merge word and registered response
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_addr       <= '0;
         r_size       <= '0;
         r_we         <= 1'b0;
         r_uns        <= 1'b0;
         r_wdata      <= '0;
         r_merge      <= '0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_addr  <= req_addr[AW+1:0];
            r_size  <= req_size;
            r_we    <= req_we;
            r_uns   <= req_unsigned;
            r_wdata <= req_wdata;
         end
         if (r_state == MERGE) r_merge <= w_merged;
         r_resp_valid <= w_next == RESP || w_next == ERR;
         r_resp_err   <= w_next == ERR;
         r_resp_rdata <= r_state == RDATA ? w_load : w_accept ? '0 : r_resp_rdata;
      end

   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_err;
   assign resp_rdata = r_resp_rdata;

`ifdef LSU_PERF_CNT_EN
   logic [15:0] r_loads, r_stores, r_errs;
   // saturating completion counters, bumped on each response
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_loads  <= '0;
         r_stores <= '0;
         r_errs   <= '0;
      end else if (r_resp_valid) begin
         r_errs   <= r_errs   + 16'(r_resp_err && r_errs != 16'hFFFF);
         r_stores <= r_stores + 16'(!r_resp_err && r_we && r_stores != 16'hFFFF);
         r_loads  <= r_loads  + 16'(!r_resp_err && !r_we && r_loads != 16'hFFFF);
      end
   assign perf_loads  = r_loads;
   assign perf_stores = r_stores;
   assign perf_errs   = r_errs;
`endif
endmodule

// File: tb/tb_riscv_lsu_rmw.sv
// tb_riscv_lsu_rmw: randomized self-checking bench for riscv_lsu_rmw against a byte-array memory model
module tb_riscv_lsu_rmw;
   localparam int AW = 7;
   localparam int NB = 4 << AW;
   logic          clk = 0, rst_n = 0;
   logic          req_valid = 0, req_we = 0, req_unsigned = 0;
   logic [1:0]    req_size = 0;
   logic [31:0]   req_addr = 0, req_wdata = 0;
   logic          req_ready, resp_valid, resp_err, mem_en, mem_we;
   logic [31:0]   resp_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;
`ifdef LSU_PERF_CNT_EN
   logic [15:0]   perf_loads, perf_stores, perf_errs;
`endif
   logic [31:0]   ram [0:(1<<AW)-1];
   logic [7:0]    mb [0:NB-1];
   int            tests = 0, fails = 0, n_wr = 0, n_acc = 0, last_wa = -1;
   int            e_ld = 0, e_st = 0, e_er = 0;

   riscv_lsu_rmw #(.AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_en(mem_en),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef LSU_PERF_CNT_EN
      , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_errs(perf_errs)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en && mem_we) begin ram[mem_addr] <= mem_wdata; n_wr++; last_wa = int'(mem_addr); end
      else if (mem_en) mem_rdata <= ram[mem_addr];
      if (req_valid && req_ready) n_acc++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input bit hold);
      bit err, en_seen, busy_rdy;
      int nb, lat, exp_lat, exp_wr, wr0, acc0;
      logic [31:0] exp;
      err = sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 0) || a >= NB;
      nb  = sz == 0 ? 1 : sz == 1 ? 2 : 4;
      exp = 0;
      if (!err && !we) begin
         for (int i = 0; i < nb; i++) exp |= 32'(mb[a + i]) << (8 * i);
         if (!uns && nb < 4 && exp[8*nb-1]) exp |= 32'hFFFF_FFFF << (8 * nb);
      end
      if (!err && we) for (int i = 0; i < nb; i++) mb[a + i] = 8'(wd >> (8 * i));
      if (err) e_er++; else if (we) e_st++; else e_ld++;
      exp_lat = err ? 1 : !we ? 3 : sz == 2 ? 2 : 4;
      exp_wr  = (!err && we) ? 1 : 0;
      @(negedge clk);
      req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
      check("ready_idle", 32'(req_ready), 1);
      wr0 = n_wr; acc0 = n_acc;
      @(posedge clk);
      if (!hold) #1 req_valid = 0;
      lat = 0; en_seen = 0; busy_rdy = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (mem_en) en_seen = 1;
         if (req_ready) busy_rdy = 1;
         if (resp_valid) begin lat = k; break; end
      end
      check("latency", 32'(lat), 32'(exp_lat));
      check("resp_err", 32'(resp_err), 32'(err));
      check("resp_rdata", resp_rdata, exp);
      check("mem_writes", 32'(n_wr - wr0), 32'(exp_wr));
      check("accepts", 32'(n_acc - acc0), 1);
      check("busy_ready", 32'(busy_rdy), 0);
      if (err) check("err_no_en", 32'(en_seen), 0);
   endtask

   initial begin
      int wr0;
      for (int i = 0; i < (1 << AW); i++) begin
         ram[i] = $urandom;
         for (int j = 0; j < 4; j++) mb[4*i + j] = 8'(ram[i] >> (8 * j));
      end
      #1;
      check("rst_ready", 32'(req_ready), 0);
      repeat (3) @(negedge clk);
      check("rst_resp_valid", 32'(resp_valid), 0);
      check("rst_resp_err", 32'(resp_err), 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_mem_en", 32'(mem_en), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_wdata", mem_wdata, 0);
      rst_n = 1;

      do_req(1, 2, 0, 32'h0C, 32'hDEADBEEF, 0);
      check("sw_addr", 32'(last_wa), 3);
      do_req(0, 2, 0, 32'h0C, 0, 0);
      do_req(1, 0, 0, 32'h0D, 32'h000000AA, 0);
      check("sb_addr", 32'(last_wa), 3);
      check("sb_word", ram[3], 32'hDEADAAEF);
      do_req(0, 0, 0, 32'h0D, 0, 0);
      do_req(0, 0, 1, 32'h0D, 0, 0);
      do_req(1, 1, 0, 32'h0E, 32'h00001234, 0);
      check("sh_word", ram[3], 32'h1234AAEF);
      do_req(0, 1, 0, 32'h0E, 0, 0);
      do_req(0, 1, 1, 32'h0C, 0, 0);
      do_req(0, 2, 0, 32'h0E, 0, 0);
      do_req(1, 1, 0, 32'h0D, 32'h5555, 0);
      do_req(0, 3, 0, 32'h10, 0, 0);
      do_req(0, 2, 0, 32'h200, 0, 0);
      do_req(1, 0, 0, 32'h8000_0000, 32'h77, 1);
      do_req(1, 1, 0, 32'h22, 32'hBEEF, 1);
      do_req(0, 1, 0, 32'h22, 0, 1);
      do_req(1, 2, 0, 32'h24, 32'hCAFEF00D, 1);

      @(negedge clk);
      req_valid = 1; req_we = 1; req_size = 0; req_unsigned = 0; req_addr = 32'h0C; req_wdata = 32'h55;
      wr0 = n_wr;
      @(posedge clk);
      #1 req_valid = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 0;
      #1;
      check("abort_mem_en", 32'(mem_en), 0);
      check("abort_ready", 32'(req_ready), 0);
      repeat (2) @(negedge clk);
      check("abort_resp", 32'(resp_valid), 0);
      rst_n = 1;
      check("abort_writes", 32'(n_wr - wr0), 0);
      check("abort_ram", ram[3], 32'h1234AAEF);
`ifdef LSU_PERF_CNT_EN
      e_ld = 0; e_st = 0; e_er = 0;
`endif
      do_req(0, 2, 0, 32'h0C, 0, 0);

      for (int n = 0; n < 300; n++) begin
         logic [1:0] sz;
         logic [31:0] a;
         sz = 2'($urandom_range(0, 3));
         a  = $urandom_range(0, NB - 1);
         if ($urandom_range(0, 9) < 7) a &= sz == 2 ? 32'hFFFF_FFFC : sz == 1 ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
         if ($urandom_range(0, 9) == 0) a |= 32'h1 << $urandom_range(AW + 2, 31);
         do_req(1'($urandom), sz, 1'($urandom), a, $urandom, bit'($urandom_range(0, 1)));
      end
      @(negedge clk);
      req_valid = 0;
      for (int i = 0; i < (1 << AW); i++)
         check("ram_final", ram[i], {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]});
`ifdef LSU_PERF_CNT_EN
      check("perf_loads", 32'(perf_loads), 32'(e_ld));
      check("perf_stores", 32'(perf_stores), 32'(e_st));
      check("perf_errs", 32'(perf_errs), 32'(e_er));
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
